aes_key_expand: RTL and testbench
=================================

Name: aes_key_expand

Overview:
Iterative AES-128 key schedule generator. It consumes the round-constant lookup (SubRcon) and the byte S-box, and produces round keys 0..NR one per handshake for the downstream cipher rounds. A valid/ready stream on both sides lets the CTR datapath stall the schedule.

Parameters:
NR, 10, number of rounds to generate after round key 0; legal range 1..10 (values below 10 are for reduced-round debug only)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
key_in  in  128  cipher key, byte 0 in [127:120]
key_valid  in  1  key_in valid
key_ready  out  1  block idle and can accept a key
rk_out  out  128  current round key, word w0 in [127:96]
rk_idx  out  4  round index of rk_out (0..NR)
rk_valid  out  1  rk_out/rk_idx valid
rk_ready  in  1  downstream accepts rk_out
busy  out  1  schedule in progress

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset (rst high at a clock edge, overrides all else): state=IDLE, rk_out=0, rk_idx=0, rk_valid=0, busy=0. key_ready=1 from the first edge with rst high.
- Inputs sampled while rst is high are ignored.
- key_ready = (state==IDLE), combinational from the state register.
- States: IDLE, EMIT.
- IDLE: on key_valid & key_ready at edge T, register rk_out=key_in and rk_idx=0, then enter EMIT. rk_valid=1 and busy=1 from T+1.
- EMIT: rk_out and rk_idx hold stable while rk_valid & !rk_ready, with no limit on the stall length.
- EMIT, on an rk_valid & rk_ready edge with rk_idx<NR:
  - rk_out <= next(rk_out); rk_idx <= rk_idx+1; rk_valid stays 1.
- EMIT, on an rk_valid & rk_ready edge with rk_idx==NR: go to IDLE; rk_valid=0, busy=0, key_ready=1 next cycle.
- Round function next(w0,w1,w2,w3):
  - t = SubWord(RotWord(w3)) ^ {rcon,24'h0}.
  - RotWord({a,b,c,d}) = {b,c,d,a}.
  - SubWord uses 4 parallel S-box instances.
  - rcon = SubRcon(rk_idx+1), zero-extended to 8 bits, so index 1 gives 8'h01 and index 10 gives 8'h36.
  - n0=w0^t, n1=w1^n0, n2=w2^n1, n3=w3^n2.
  - The whole path is combinational in one cycle; no other pipelining.
- Latency: with rk_ready tied high, round key i is valid during cycle T+1+i. The last key (NR) is at T+1+NR and key_ready=1 at T+2+NR. The next key can be accepted at T+2+NR, so there are no idle bubbles beyond that.
- key_valid while busy: ignored, not queued. key_in need not be held after acceptance.
- The final handshake and a new key cannot overlap, because key_ready is 0 in EMIT.
- rst during EMIT: the schedule is abandoned immediately. rk_valid=0 from the next edge, with no partial output afterwards.
- rk_idx never exceeds NR. The rcon index never exceeds 10.

Test Plan:
1. FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1 → rk0 = key; rk1 = a0fafe1788542cb123a339392a6c7605; rk10 = d014f9a8c9ee2589e13f0cc8b6630ca6 at T+11; key_ready=1 at T+12.
2. Zero key → rk1 = 62636363626363636263636362636363; rk10 = b4ef5bcb3e92e21123e951cf6f8f188e; rk_idx steps 0..10 with no gaps.
3. Random rk_ready stalls of 0-5 cycles on the FIPS key → same 11 keys in order; rk_out and rk_idx stable across every stall cycle.
4. key_valid held high throughout with a second key → second key accepted only at T+12, and its rk0 appears at T+13. key_ready=0 for all of T+1..T+11.
5. rst at rk_idx=4 during a stall → next cycle rk_valid=0, busy=0, key_ready=1. The next key after reset produces a correct full schedule.
6. NR=1 build with the FIPS key → exactly two keys (rk0, then a0fafe17...7605 with rk_idx=1), then IDLE.

Source files
------------

// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule: emits round keys 0..NR, one per rk_valid/rk_ready handshake.
// The byte S-box is computed in GF(2^8) (multiplicative inverse as x^254, then the affine map).

module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] s
);
    function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] p;
        logic [7:0] m;
        p = 8'h00;
        m = x;
        for (int i = 0; i < 8; i++) begin
            if (y[i]) p = p ^ m;
            m = {m[6:0], 1'b0} ^ (m[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    logic [7:0] inv;
    logic [7:0] sq;

    // x^254 = product of x^(2^k) for k=1..7; maps 0 to 0 as the S-box requires
    always_comb begin
        inv = 8'h01;
        sq  = gmul(a, a);
        for (int k = 1; k < 8; k++) begin
            inv = gmul(inv, sq);
            sq  = gmul(sq, sq);
        end
    end

    assign s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
             ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
endmodule

module aes_key_expand #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] key_in,
    input  logic         key_valid,
    output logic         key_ready,
    output logic [127:0] rk_out,
    output logic [3:0]   rk_idx,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic         busy
);
    typedef enum logic {IDLE, EMIT} state_t;

    state_t       state_q, state_d;
    logic [127:0] rk_q, rk_next;
    logic [3:0]   idx_q;
    logic         load, advance;
    logic [31:0]  rot_w, sub_w, t;
    logic [31:0]  n0, n1, n2, n3;
    logic [3:0]   rcon_idx;
    logic [7:0]   rcon;

    assign rot_w = {rk_q[23:0], rk_q[31:24]};

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        aes_sbox u_sbox (
            .a (rot_w[8*g +: 8]),
            .s (sub_w[8*g +: 8])
        );
    end

    // clamp so the lookup never sees an index past 10, even on the last round key
    assign rcon_idx = (idx_q >= 4'd10) ? 4'd10 : idx_q + 4'd1;

    always_comb begin
        case (rcon_idx)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    always_comb begin
        t       = sub_w ^ {rcon, 24'h0};
        n0      = rk_q[127:96] ^ t;
        n1      = rk_q[95:64]  ^ n0;
        n2      = rk_q[63:32]  ^ n1;
        n3      = rk_q[31:0]   ^ n2;
        rk_next = {n0, n1, n2, n3};
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        advance = 1'b0;
        case (state_q)
            IDLE: begin
                if (key_valid) begin
                    load    = 1'b1;
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (rk_ready) begin
                    if (idx_q == 4'(NR)) state_d = IDLE;
                    else                 advance = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rk_q    <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                rk_q  <= key_in;
                idx_q <= '0;
            end else if (advance) begin
                rk_q  <= rk_next;
                idx_q <= idx_q + 4'd1;
            end
        end
    end

    assign key_ready = (state_q == IDLE);
    assign rk_valid  = (state_q == EMIT);
    assign busy      = (state_q == EMIT);
    assign rk_out    = rk_q;
    assign rk_idx    = idx_q;
endmodule

// File: tb/tb_aes_key_expand.sv
// Randomised bench for aes_key_expand against a word-wise FIPS-197 key expansion model.
module tb_aes_key_expand;
    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] key_in;
    logic         key_valid, key_ready, rk_valid, rk_ready, busy;
    logic [127:0] rk_out;
    logic [3:0]   rk_idx;
    logic         key_valid1, key_ready1, rk_valid1, rk_ready1, busy1;
    logic [127:0] rk_out1;
    logic [3:0]   rk_idx1;

    int checks = 0;
    int errors = 0;

    logic [7:0]   sbox_tab [256];
    logic [127:0] exp_rk   [11];
    logic [127:0] got_rk   [11];

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    always #5 clk = ~clk;

    aes_key_expand #(.NR(10)) u_dut (
        .clk(clk), .rst(rst), .key_in(key_in), .key_valid(key_valid), .key_ready(key_ready),
        .rk_out(rk_out), .rk_idx(rk_idx), .rk_valid(rk_valid), .rk_ready(rk_ready), .busy(busy)
    );

    aes_key_expand #(.NR(1)) u_dut1 (
        .clk(clk), .rst(rst), .key_in(key_in), .key_valid(key_valid1), .key_ready(key_ready1),
        .rk_out(rk_out1), .rk_idx(rk_idx1), .rk_valid(rk_valid1), .rk_ready(rk_ready1), .busy(busy1)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, got, exp);
        end
    endtask

    // carry-less product then polynomial reduction by x^8+x^4+x^3+x+1
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] prod;
        prod = 16'h0;
        for (int i = 0; i < 8; i++)
            if (b[i]) prod = prod ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--)
            if (prod[i]) prod = prod ^ (16'h011b << (i - 8));
        return prod[7:0];
    endfunction

    task automatic build_sbox();
        logic [7:0] inv, s, c;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            for (int i = 0; i < 8; i++)
                s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
            sbox_tab[x] = s;
        end
    endtask

    task automatic model_expand(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] tmp;
        logic [7:0]  rc;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sbox_tab[tmp[31:24]], sbox_tab[tmp[23:16]],
                       sbox_tab[tmp[15:8]],  sbox_tab[tmp[7:0]]};
                tmp[31:24] = tmp[31:24] ^ rc;
                rc = gf_mul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // called on a negedge; returns on the negedge of the first cycle after acceptance
    task automatic send_key(input logic [127:0] k);
        key_in    = k;
        key_valid = 1'b1;
        chk("key_ready_idle", 128'(key_ready), 128'd1);
        @(negedge clk);
        key_valid = 1'b0;
        key_in    = {$urandom, $urandom, $urandom, $urandom};
    endtask

    // walks rounds 0..10 with random stalls, checking hold-stability on every stalled cycle
    task automatic check_sched(input int stall_max);
        int s;
        for (int i = 0; i <= 10; i++) begin
            s = (stall_max > 0) ? int'($urandom_range(0, stall_max)) : 0;
            got_rk[i] = rk_out;
            for (int c = 0; c <= s; c++) begin
                chk("rk_valid", 128'(rk_valid), 128'd1);
                chk("rk_idx", 128'(rk_idx), 128'(i));
                chk("rk_out", rk_out, exp_rk[i]);
                chk("busy_key_ready", 128'({busy, key_ready}), 128'b10);
                rk_ready = (c == s);
                @(negedge clk);
            end
        end
        chk("done_state", 128'({rk_valid, busy, key_ready}), 128'b001);
    endtask

    initial begin
        logic [127:0] k2;
        rst = 1'b1; key_valid = 1'b0; key_valid1 = 1'b0; rk_ready = 1'b1; rk_ready1 = 1'b1;
        key_in = {$urandom, $urandom, $urandom, $urandom};
        build_sbox();
        repeat (2) @(negedge clk);
        key_valid = 1'b1;
        @(negedge clk);
        chk("rst_outs", 128'({rk_valid, busy, key_ready, rk_idx}), 128'b0010000);
        chk("rst_rk_out", rk_out, 128'h0);
        chk("rst_dut1", 128'({rk_valid1, busy1, key_ready1}), 128'b001);
        key_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);

        // FIPS-197 vector, no stalls: latency is implied by one check per cycle
        model_expand(FIPS_KEY);
        send_key(FIPS_KEY);
        check_sched(0);
        chk("fips_rk0", got_rk[0], FIPS_KEY);
        chk("fips_rk1", got_rk[1], 128'ha0fafe1788542cb123a339392a6c7605);
        chk("fips_rk10", got_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        model_expand(128'h0);
        send_key(128'h0);
        check_sched(0);
        chk("zero_rk1", got_rk[1], 128'h62636363626363636263636362636363);
        chk("zero_rk10", got_rk[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

        model_expand(FIPS_KEY);
        send_key(FIPS_KEY);
        check_sched(5);
        chk("stall_rk10", got_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // key_valid held high: the second key must wait until the schedule returns to IDLE
        k2 = {$urandom, $urandom, $urandom, $urandom};
        model_expand(FIPS_KEY);
        key_in = FIPS_KEY; key_valid = 1'b1;
        @(negedge clk);
        key_in = k2;
        check_sched(0);
        model_expand(k2);
        @(negedge clk);
        key_valid = 1'b0;
        check_sched(0);

        // reset mid-schedule while stalled at round 4
        model_expand(FIPS_KEY);
        send_key(FIPS_KEY);
        for (int i = 0; i < 4; i++) @(negedge clk);
        rk_ready = 1'b0;
        @(negedge clk);
        chk("pre_rst_idx", 128'(rk_idx), 128'd4);
        chk("pre_rst_rk", rk_out, exp_rk[4]);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_outs", 128'({rk_valid, busy, key_ready}), 128'b001);
        rk_ready = 1'b1;
        @(negedge clk);
        chk("post_rst_idle", 128'({rk_valid, busy, key_ready}), 128'b001);
        k2 = {$urandom, $urandom, $urandom, $urandom};
        model_expand(k2);
        send_key(k2);
        check_sched(2);

        for (int n = 0; n < 4; n++) begin
            k2 = {$urandom, $urandom, $urandom, $urandom};
            model_expand(k2);
            send_key(k2);
            check_sched(3);
        end

        // reduced-round build: two keys, then back to IDLE
        key_in = FIPS_KEY; key_valid1 = 1'b1;
        @(negedge clk);
        key_valid1 = 1'b0;
        chk("nr1_rk0", rk_out1, FIPS_KEY);
        chk("nr1_idx0", 128'({rk_valid1, rk_idx1}), 128'b10000);
        @(negedge clk);
        chk("nr1_rk1", rk_out1, 128'ha0fafe1788542cb123a339392a6c7605);
        chk("nr1_idx1", 128'({rk_valid1, rk_idx1}), 128'b10001);
        @(negedge clk);
        chk("nr1_done", 128'({rk_valid1, busy1, key_ready1}), 128'b001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
